uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO and a run-time bit period.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high; aborts any frame and empties the FIFO
//   s_data     - word to send (DATA_BITS wide, transmitted LSB first)
//   s_valid    - s_data valid; accepted on an edge where s_valid && s_ready
//   s_ready    - registered "FIFO not full"
//   clk_div    - clocks per bit, latched at each frame start (0 and 1 act as 2)
//   brk        - request a break (line held low) while asserted, honoured when idle
//   out        - registered serial line, idle high
//   busy       - frame in progress or FIFO non-empty
//   fifo_count - number of words currently held in the FIFO
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DIV_WIDTH-1:0]        clk_div,
  input  logic                        brk,
  output logic                        out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW   = $clog2(MAXB + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  // Bit periods below two clocks are raised to two.
  function automatic logic [DIV_WIDTH-1:0] sat_period(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  // FIFO storage and pointers; pointers wrap naturally since the depth is a power of two.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_n;
  logic                 push, pop, empty;

  // Transmit state
  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_n;
  logic [DIV_WIDTH-1:0] period, period_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n, cnt_adv;
  logic [BW-1:0]        bitn, bitn_n;
  logic                 out_n, load, bit_end;

  assign empty   = (fifo_count == '0);
  assign push    = s_valid && s_ready;
  assign pop     = load;
  assign count_n = fifo_count + CW'(push) - CW'(pop);
  assign busy    = (state != S_IDLE) || !empty;

  assign bit_end = (cnt == period - DIV_WIDTH'(1));
  assign cnt_adv = bit_end ? '0 : cnt + DIV_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // s_ready is derived from the next count so it is exact on every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      s_ready    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_n;
      s_ready    <= (count_n != DEPTH_C);
    end
  end

  // State/control registers; the line value is registered from the current state,
  // which places the falling start edge two clocks after the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      out   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      out   <= out_n;
    end
  end

  always_ff @(posedge clk) begin
    shift   <= shift_n;
    par_bit <= par_n;
    period  <= period_n;
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    par_n    = par_bit;
    period_n = period;
    cnt_n    = cnt;
    bitn_n   = bitn;
    out_n    = 1'b1;
    load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (brk)         state_n = S_BREAK;
        else if (!empty) load    = 1'b1;
      end
      S_START: begin
        out_n = 1'b0;
        cnt_n = cnt_adv;
        if (bit_end) begin
          bitn_n  = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        out_n = shift[0];
        cnt_n = cnt_adv;
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bitn == LAST_DATA) begin
            bitn_n  = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bitn_n = bitn + BW'(1);
          end
        end
      end
      S_PARITY: begin
        // par_bit holds the XOR of the data bits: even parity sends it, odd inverts it.
        out_n = (PARITY == 2) ? par_bit : ~par_bit;
        cnt_n = cnt_adv;
        if (bit_end) begin
          bitn_n  = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        out_n = 1'b1;
        cnt_n = cnt_adv;
        if (bit_end) begin
          // Last stop bit chains straight into the next frame when data is waiting.
          if (bitn == LAST_STOP) begin
            if (!empty) load    = 1'b1;
            else        state_n = S_IDLE;
          end else begin
            bitn_n = bitn + BW'(1);
          end
        end
      end
      S_BREAK: begin
        out_n = ~brk;
        if (!brk) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (load) begin
      shift_n  = mem[rd_ptr];
      par_n    = ^mem[rd_ptr];
      period_n = sat_period(clk_div);
      cnt_n    = '0;
      bitn_n   = '0;
      state_n  = S_START;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Five instances with different parameter sets share the same stimulus:
//   0: 8N1 depth 16, 1: even parity, 2: odd parity, 3: two stop bits, 4: depth 4.
module tb_uart_tx_fifo;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  s_data  = 8'h00;
  logic        s_valid = 1'b0;
  logic [15:0] clk_div = 16'd4;
  logic        brk     = 1'b0;

  logic out0, out1, out2, out3, out4;
  logic rdy0, rdy1, rdy2, rdy3, rdy4;
  logic busy0, busy1, busy2, busy3, busy4;
  logic [4:0] cnt0, cnt1, cnt2, cnt3;
  logic [2:0] cnt4;
  logic [4:0] out_w, busy_w;

  assign out_w  = {out4, out3, out2, out1, out0};
  assign busy_w = {busy4, busy3, busy2, busy1, busy0};

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy0),
    .clk_div(clk_div), .brk(brk), .out(out0), .busy(busy0), .fifo_count(cnt0));
  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy1),
    .clk_div(clk_div), .brk(brk), .out(out1), .busy(busy1), .fifo_count(cnt1));
  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut2 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy2),
    .clk_div(clk_div), .brk(brk), .out(out2), .busy(busy2), .fifo_count(cnt2));
  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(0), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy3),
    .clk_div(clk_div), .brk(brk), .out(out3), .busy(busy3), .fifo_count(cnt3));
  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy4),
    .clk_div(clk_div), .brk(brk), .out(out4), .busy(busy4), .fifo_count(cnt4));

  // Receiver for instance 4, fixed at 20 clocks per bit, sampling mid-bit on the falling edge.
  bit         mon_en  = 1'b0;
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_act <= 1'b0;
      mon_cnt <= 0;
    end else if (!mon_act) begin
      if (out4 == 1'b0) begin
        mon_act <= 1'b1;
        mon_cnt <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt >= 30 && mon_cnt < 190 && ((mon_cnt - 30) % 20) == 0)
        mon_byte[3'((mon_cnt - 30) / 20)] <= out4;
      if (mon_cnt == 190) begin
        rx_q.push_back(mon_byte);
        mon_act <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    brk     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Checks one frame on instance d sample by sample, starting at its first start-bit sample.
  // With last set, busy is required low on the final stop-bit sample.
  task automatic expect_frame(input int d, input string tag, input logic [7:0] data,
                              input int p, input bit has_par, input bit pbit,
                              input int stops, input bit last);
    logic [15:0] fb;
    int          nb;
    fb    = '0;
    fb[0] = 1'b0;
    nb    = 1;
    for (int i = 0; i < 8; i++) begin
      fb[nb] = data[i];
      nb++;
    end
    if (has_par) begin
      fb[nb] = pbit;
      nb++;
    end
    for (int i = 0; i < stops; i++) begin
      fb[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < p; k++) begin
        check({tag, " out"}, 32'(out_w[d]), 32'(fb[b]));
        check({tag, " busy"}, 32'(busy_w[d]),
              (last && b == nb - 1 && k == p - 1) ? 32'd0 : 32'd1);
        tick();
      end
    end
  endtask

  logic [7:0] wq [6];
  bit         pe_a5 [3];
  bit         pe_01 [3];
  logic       rdy;
  int         acc;
  int         guard;

  initial begin
    // Reset values
    tick();
    tick();
    check("rst out", 32'(out0), 32'd1);
    check("rst s_ready", 32'(rdy0), 32'd0);
    check("rst busy", 32'(busy0), 32'd0);
    check("rst count", 32'(cnt0), 32'd0);
    check("rst count f4", 32'(cnt4), 32'd0);
    reset = 1'b0;
    tick();
    check("post-rst s_ready", 32'(rdy0), 32'd1);
    check("post-rst s_ready f4", 32'(rdy4), 32'd1);
    check("post-rst out", 32'(out0), 32'd1);

    // 8N1, 4 clocks per bit, 0xA5
    clk_div = 16'd4;
    push(8'hA5);
    check("8n1 count after push", 32'(cnt0), 32'd1);
    check("8n1 busy after push", 32'(busy0), 32'd1);
    tick();
    check("8n1 out N+1", 32'(out0), 32'd1);
    check("8n1 count after pop", 32'(cnt0), 32'd0);
    tick();
    expect_frame(0, "8n1 A5", 8'hA5, 4, 1'b0, 1'b0, 1, 1'b1);
    check("8n1 idle out", 32'(out0), 32'd1);
    check("8n1 idle busy", 32'(busy0), 32'd0);

    // Parity: even (instance 1) then odd (instance 2); hand-computed parity bits
    pe_a5[1] = 1'b0; pe_01[1] = 1'b1;
    pe_a5[2] = 1'b1; pe_01[2] = 1'b0;
    for (int d = 1; d <= 2; d++) begin
      do_reset();
      push(8'hA5);
      tick();
      tick();
      expect_frame(d, "par A5", 8'hA5, 4, 1'b1, pe_a5[d], 1, 1'b1);
      tick();
      push(8'h01);
      tick();
      tick();
      expect_frame(d, "par 01", 8'h01, 4, 1'b1, pe_01[d], 1, 1'b1);
    end

    // Two stop bits, 3 clocks per bit, three back-to-back frames
    do_reset();
    clk_div = 16'd3;
    push(8'h00);
    check("s2 count 1", 32'(cnt3), 32'd1);
    push(8'hFF);
    push(8'h55);
    check("s2 count 2", 32'(cnt3), 32'd2);
    expect_frame(3, "s2 00", 8'h00, 3, 1'b0, 1'b0, 2, 1'b0);
    check("s2 count after f1", 32'(cnt3), 32'd1);
    expect_frame(3, "s2 FF", 8'hFF, 3, 1'b0, 1'b0, 2, 1'b0);
    check("s2 count after f2", 32'(cnt3), 32'd0);
    expect_frame(3, "s2 55", 8'h55, 3, 1'b0, 1'b0, 2, 1'b1);
    check("s2 end busy", 32'(busy3), 32'd0);
    check("s2 end out", 32'(out3), 32'd1);

    // Depth-4 FIFO with a slow transmitter and s_valid held
    do_reset();
    clk_div = 16'd20;
    mon_en  = 1'b1;
    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
    wq[3] = 8'h44; wq[4] = 8'h55; wq[5] = 8'h66;
    acc   = 0;
    guard = 0;
    s_valid = 1'b1;
    while (acc < 6 && guard < 1000) begin
      s_data = wq[acc];
      rdy    = rdy4;
      tick();
      guard++;
      if (rdy) begin
        acc++;
        if (acc == 5) begin
          check("f4 full count", 32'(cnt4), 32'd4);
          check("f4 full s_ready", 32'(rdy4), 32'd0);
          tick();
          check("f4 held s_ready", 32'(rdy4), 32'd0);
          check("f4 held count", 32'(cnt4), 32'd4);
        end
      end
    end
    s_valid = 1'b0;
    check("f4 accepted", 32'(acc), 32'd6);
    guard = 0;
    while (rx_q.size() < 6 && guard < 3000) begin
      tick();
      guard++;
    end
    check("f4 frames received", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check("f4 order", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(wq[i]));
    for (int i = 0; i < 20; i++) tick();
    mon_en = 1'b0;
    check("f4 drained count", 32'(cnt4), 32'd0);
    check("f4 drained busy", 32'(busy4), 32'd0);

    // clk_div changed mid-frame, then clk_div = 0
    do_reset();
    clk_div = 16'd4;
    push(8'h3C);
    push(8'hC3);
    clk_div = 16'd8;
    tick();
    expect_frame(0, "div4 3C", 8'h3C, 4, 1'b0, 1'b0, 1, 1'b0);
    expect_frame(0, "div8 C3", 8'hC3, 8, 1'b0, 1'b0, 1, 1'b1);
    clk_div = 16'd0;
    push(8'h96);
    tick();
    tick();
    expect_frame(0, "div0 96", 8'h96, 2, 1'b0, 1'b0, 1, 1'b1);

    // Break requested while a frame is in flight
    clk_div = 16'd4;
    tick();
    push(8'h5A);
    tick();
    brk = 1'b1;
    tick();
    expect_frame(0, "brk 5A", 8'h5A, 4, 1'b0, 1'b0, 1, 1'b1);
    check("brk entry out", 32'(out0), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("brk low", 32'(out0), 32'd0);
      check("brk busy", 32'(busy0), 32'd1);
      tick();
    end
    brk = 1'b0;
    tick();
    check("brk release out", 32'(out0), 32'd1);
    check("brk release busy", 32'(busy0), 32'd0);

    // Reset during the data bits
    push(8'h00);
    push(8'h00);
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("mid data out", 32'(out0), 32'd0);
    check("mid data count", 32'(cnt0), 32'd1);
    check("mid data busy", 32'(busy0), 32'd1);
    reset = 1'b1;
    tick();
    check("mid rst out", 32'(out0), 32'd1);
    check("mid rst count", 32'(cnt0), 32'd0);
    check("mid rst busy", 32'(busy0), 32'd0);
    check("mid rst s_ready", 32'(rdy0), 32'd0);
    reset = 1'b0;
    tick();
    check("after rst s_ready", 32'(rdy0), 32'd1);
    check("after rst out", 32'(out0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
